hwpf_req_queue: RTL
===================

HWPF_REQ_QUEUE -- requirements
Module: hwpf_req_queue

Interface
REQ-001 Parameter LINE_BYTES, default 64: cache line size in bytes; SHALL be a power of two >= 4.
REQ-002 Parameter DEPTH, default 8: queue entries; SHALL be a power of two >= 2.
REQ-003 Parameter INSERTS, default 2: prefetch insert ports and CPU demand ports, each numbering INSERTS; SHALL be >= 1 and <= DEPTH.
REQ-004 Parameter ADDR_W, default 40: physical address width.
REQ-005 Derived constant OFF_W = log2(LINE_BYTES); line address = addr[ADDR_W-1:OFF_W].
REQ-006 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 flush_i  in  1  empties the queue at the next edge.
REQ-009 en_i  in  1  0 = queue frozen.
REQ-010 pf_valid_i  in  INSERTS  per-port prefetch insert request.
REQ-011 pf_addr_i  in  INSERTS x ADDR_W  prefetch address per port.
REQ-012 cpu_valid_i  in  INSERTS  per-port CPU demand request issued.
REQ-013 cpu_addr_i  in  INSERTS x ADDR_W  CPU demand address per port.
REQ-014 cpu_hit_o  out  INSERTS  demand line matches a live queued prefetch.
REQ-015 arb_valid_o  out  1  head entry offered to the memory arbiter.
REQ-016 arb_addr_o  out  ADDR_W  head line address, offset bits forced to 0.
REQ-017 arb_ready_i  in  1  arbiter accepts the head.
REQ-018 count_o  out  log2(DEPTH)+1  live entry count.
REQ-019 full_o  out  1  count_o == DEPTH.
REQ-020 drop_o  out  INSERTS  pulse, one cycle: the insert on that port was discarded for lack of space.

Function
REQ-021 The queue SHALL be age-ordered; the head SHALL be the oldest live entry, and removing any entry SHALL compact the younger entries toward the head by the next edge.
REQ-022 arb_valid_o SHALL be en_i && count_o != 0; arb_addr_o SHALL come combinationally from registered head state; no latency beyond that.
REQ-023 Pop SHALL occur when arb_valid_o && arb_ready_i; arb_addr_o SHALL remain stable while arb_valid_o=1 and arb_ready_i=0, unless that entry is cancelled.
REQ-024 cpu_hit_o[k] SHALL be combinational: cpu_valid_i[k] && en_i && a live entry's line address equals cpu_addr_i[k]'s line address.
REQ-025 Every entry matched by any cpu_hit_o SHALL be removed at the edge; an entry that is both popped and cancelled SHALL be removed once.
REQ-026 Inserts SHALL be placed after removals, in ascending port order, into space freed by that cycle's pop and cancels; an insert finding no space SHALL assert drop_o[k].
REQ-027 An insert whose line equals a same-cycle cpu_valid line SHALL be discarded without drop_o.
REQ-028 count_o next SHALL be count - pops - cancels + accepted inserts, never above DEPTH or below 0.
REQ-029 With en_i=0: no pop, insert or cancel; cpu_hit_o=0 and drop_o=0; state held.
REQ-030 flush_i=1 SHALL clear all entries at the edge, ignoring that cycle's inserts; drop_o=0 and cpu_hit_o unaffected. flush_i SHALL take priority over en_i.

Reset
REQ-031 With rst_i=1 at an edge, all entries SHALL become invalid and count_o=0. Outputs after reset: arb_valid_o=0, arb_addr_o=0, full_o=0, drop_o=0, cpu_hit_o=0.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries, with no partial pop.

Configuration
REQ-033 Macro HWPF_QUEUE_DEDUP_EN.
REQ-034 Defined: an insert whose line matches a surviving entry, or an earlier-port accepted insert in the same cycle, SHALL be silently discarded (no drop_o, no count change).
REQ-035 Undefined: duplicate lines SHALL be inserted as distinct entries, and one cpu hit SHALL cancel all of them.

Verification
REQ-036 Reset, then pf_valid_i=01 with 0x1040 -> next cycle count_o=1, arb_valid_o=1, arb_addr_o=0x1040.
REQ-037 Fill 8 entries, hold arb_ready_i=0, insert 0x2000 on port 0 -> drop_o=01, full_o=1, head unchanged.
REQ-038 Queue holds 0x1000, 0x1040, 0x1080; cpu_valid_i=01 with 0x1047 -> cpu_hit_o=01 that cycle; next cycle count_o=2, order 0x1000 then 0x1080.
REQ-039 Full queue, pop head plus insert 0x3000 on both ports in the same cycle -> port 0 accepted, drop_o=10, count_o stays 8.
REQ-040 HWPF_QUEUE_DEDUP_EN defined, 0x1040 queued, insert 0x1050 -> count_o unchanged, drop_o=0; without the macro -> count_o increments.
REQ-041 Flush with 5 entries and concurrent inserts, then en_i=0 with pf_valid_i=11 -> count_o=0 after the flush and stays 0, arb_valid_o=0.

Source files
------------

// File: rtl/hwpf_req_queue_if.sv
// Hardware prefetch request queue bus.
// Groups the prefetch insert ports, the CPU demand lookup ports, the
// per-port drop pulses and the arbiter head handshake.
//   pf_valid_i/pf_addr_i   : prefetch insert requests, one per port
//   cpu_valid_i/cpu_addr_i : CPU demand addresses, one per port
//   cpu_hit_o              : demand line matches a live queued prefetch
//   drop_o                 : insert on that port discarded for lack of space
//   arb_valid_o/arb_addr_o : head entry offered to the memory arbiter
//   arb_ready_i            : arbiter accepts the head
// Signal suffixes are from the queue's point of view (slave modport).
interface hwpf_req_queue_if #(
  parameter int INSERTS = 2,
  parameter int ADDR_W  = 40
);
  logic [INSERTS-1:0]             pf_valid_i;
  logic [INSERTS-1:0][ADDR_W-1:0] pf_addr_i;
  logic [INSERTS-1:0]             cpu_valid_i;
  logic [INSERTS-1:0][ADDR_W-1:0] cpu_addr_i;
  logic [INSERTS-1:0]             cpu_hit_o;
  logic [INSERTS-1:0]             drop_o;
  logic                           arb_valid_o;
  logic [ADDR_W-1:0]              arb_addr_o;
  logic                           arb_ready_i;

  modport slave (
    input  pf_valid_i, pf_addr_i, cpu_valid_i, cpu_addr_i, arb_ready_i,
    output cpu_hit_o, drop_o, arb_valid_o, arb_addr_o
  );

  modport master (
    output pf_valid_i, pf_addr_i, cpu_valid_i, cpu_addr_i, arb_ready_i,
    input  cpu_hit_o, drop_o, arb_valid_o, arb_addr_o
  );
endinterface

// File: rtl/hwpf_req_queue.sv
// Hardware prefetch request queue.
// Age-ordered queue of cache-line prefetch addresses. Entry 0 is the oldest
// and is offered to the memory arbiter. CPU demand accesses that match a
// queued line cancel it (the demand already fetches it). Removed entries are
// compacted toward the head; new inserts are appended after removals in
// ascending port order.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   flush_i  : clear all entries at the next edge (overrides en_i)
//   en_i     : 0 freezes the queue
//   bus      : hwpf_req_queue_if.slave (insert, demand, drop, arbiter)
//   count_o  : live entry count
//   full_o   : count_o == DEPTH
// Optional build macro: HWPF_QUEUE_DEDUP_EN -- inserts whose line is already
// queued (or accepted earlier in the same cycle) are silently discarded.
module hwpf_req_queue #(
  parameter int LINE_BYTES = 64,
  parameter int DEPTH      = 8,
  parameter int INSERTS    = 2,
  parameter int ADDR_W     = 40
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     en_i,
  hwpf_req_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [LINE_W-1:0] line_q [DEPTH];
  logic [LINE_W-1:0] line_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [LINE_W-1:0] cpu_line [INSERTS];
  logic [LINE_W-1:0] pf_line  [INSERTS];
  logic [DEPTH-1:0]  cancel;
  logic [INSERTS-1:0] hit;
  logic [INSERTS-1:0] drop;
  logic              pop;
  logic              dup;
  int                n;

  // Offset bits of the request addresses are intentionally ignored.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{bus.pf_addr_i, bus.cpu_addr_i};

  // Demand lookup: every live entry matching any valid demand line is
  // cancelled; the per-port hit flags come out of the same compare matrix.
  always_comb begin
    cancel = '0;
    hit    = '0;
    for (int k = 0; k < INSERTS; k++) begin
      cpu_line[k] = bus.cpu_addr_i[k][ADDR_W-1:OFF_W];
      pf_line[k]  = bus.pf_addr_i[k][ADDR_W-1:OFF_W];
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < INSERTS; k++) begin
        if (en_i && bus.cpu_valid_i[k] && (i < int'(count_q)) &&
            (line_q[i] == cpu_line[k])) begin
          cancel[i] = 1'b1;
          hit[k]    = 1'b1;
        end
      end
    end
  end

  assign bus.cpu_hit_o   = hit;
  assign bus.arb_valid_o = en_i && (count_q != '0);
  assign bus.arb_addr_o  = (count_q != '0) ? {line_q[0], {OFF_W{1'b0}}} : '0;
  assign pop             = bus.arb_valid_o && bus.arb_ready_i;

  // Next state: compact survivors toward the head (a popped head that is
  // also cancelled is skipped just once), then append inserts.
  always_comb begin
    line_d  = line_q;
    count_d = count_q;
    drop    = '0;
    dup     = 1'b0;
    n       = 0;
    if (rst_i || flush_i) begin
      count_d = '0;
    end else if (en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i < int'(count_q)) && !cancel[i] && !(pop && (i == 0))) begin
          line_d[n] = line_q[i];
          n++;
        end
      end
      for (int k = 0; k < INSERTS; k++) begin
        if (bus.pf_valid_i[k]) begin
          // A line being demanded this cycle needs no prefetch.
          dup = 1'b0;
          for (int j = 0; j < INSERTS; j++) begin
            if (bus.cpu_valid_i[j] && (cpu_line[j] == pf_line[k])) dup = 1'b1;
          end
`ifdef HWPF_QUEUE_DEDUP_EN
          // line_d[0..n-1] holds survivors plus inserts accepted so far.
          for (int i = 0; i < DEPTH; i++) begin
            if ((i < n) && (line_d[i] == pf_line[k])) dup = 1'b1;
          end
`else
`endif
          if (!dup) begin
            if (n < DEPTH) begin
              line_d[n] = pf_line[k];
              n++;
            end else begin
              drop[k] = 1'b1;
            end
          end
        end
      end
      count_d = CNT_W'(n);
    end
  end

  assign bus.drop_o = drop;
  assign count_o    = count_q;
  assign full_o     = (count_q == CNT_W'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry payload needs no reset: count_q alone defines liveness.
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
  end
endmodule
